imem_responder: RTL and testbench

IMEM_RESPONDER -- requirements
Module: imem_responder

---
 rtl/tartaruga_pkg.sv | 23 ++
 rtl/imem_array.sv | 35 +++
 rtl/imem_responder.sv | 129 ++++++++++++
 tb/tb_imem_responder.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/tartaruga_pkg.sv
// ============================================================================
// Module      : tartaruga_pkg
// Description : Shared types and constants for the instruction-memory path.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package tartaruga_pkg;

  typedef logic [31:0] bus32_t;

  // addi x0, x0, 0 -- returned in place of data on a faulted fetch
  localparam bus32_t IMEM_NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } imem_state_t;

endpackage : tartaruga_pkg

`default_nettype wire

// File: rtl/imem_array.sv
// ============================================================================
// Module      : imem_array
// Description : Instruction storage, synchronous write / asynchronous read.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module imem_array
  import tartaruga_pkg::*;
#(
  parameter  int DEPTH_WORDS = 1024,
  localparam int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk_i,
  input  logic          wr_en_i,
  input  logic [AW-1:0] wr_idx_i,
  input  bus32_t        wr_data_i,
  input  logic [AW-1:0] rd_idx_i,
  output bus32_t        rd_data_o
);

  // Deliberately not reset so a loaded image survives rstn_i.
  bus32_t r_mem [DEPTH_WORDS];

  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      r_mem[wr_idx_i] <= wr_data_i;
    end
  end

  assign rd_data_o = r_mem[rd_idx_i];

endmodule : imem_array

`default_nettype wire

// File: rtl/imem_responder.sv
// ============================================================================
// Module      : imem_responder
// Description : Fixed-latency single-outstanding instruction fetch responder.
//               Optional macro IMEM_FAULT_EN enables misaligned/range faults.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module imem_responder
  import tartaruga_pkg::*;
#(
  parameter int LATENCY     = 2,
  parameter int DEPTH_WORDS = 1024
) (
  input  logic   clk_i,
  input  logic   rstn_i,
  input  logic   req_valid_i,
  output logic   req_ready_o,
  input  bus32_t req_addr_i,
  output logic   rsp_valid_o,
  input  logic   rsp_ready_i,
  output bus32_t rsp_instr_o,
  output logic   rsp_fault_o,
  input  logic   wr_en_i,
  input  bus32_t wr_addr_i,
  input  bus32_t wr_data_i
);

  localparam int         AW       = $clog2(DEPTH_WORDS);
  localparam logic [3:0] CNT_LOAD = 4'((LATENCY >= 2) ? (LATENCY - 2) : 0);

  imem_state_t r_state;
  logic [3:0]  r_cnt;
  bus32_t      r_addr;
  logic        r_rsp_valid;
  bus32_t      r_rsp_instr;
  logic        r_rsp_fault;

  bus32_t  w_lookup_addr;
  bus32_t  w_rd_data;
  bus32_t  w_rsp_data;
  logic    w_fault;
  logic    w_unused;

  // With LATENCY == 1 the RESP-entry edge is the accept edge, so the
  // lookup must come straight from the request bus while idle.
  assign w_lookup_addr = (r_state == IDLE) ? req_addr_i : r_addr;

  imem_array #(
    .DEPTH_WORDS (DEPTH_WORDS)
  ) u_array (
    .clk_i     (clk_i),
    .wr_en_i   (wr_en_i),
    .wr_idx_i  (wr_addr_i[AW+1:2]),
    .wr_data_i (wr_data_i),
    .rd_idx_i  (w_lookup_addr[AW+1:2]),
    .rd_data_o (w_rd_data)
  );

`ifdef IMEM_FAULT_EN
  assign w_fault    = (w_lookup_addr[1:0] != 2'b00) || ((w_lookup_addr >> (AW + 2)) != '0);
  assign w_rsp_data = w_fault ? IMEM_NOP : w_rd_data;
`else
  assign w_fault    = 1'b0;
  assign w_rsp_data = w_rd_data;
`endif

  assign w_unused = ^{wr_addr_i[1:0], wr_addr_i[31:AW+2], w_lookup_addr};

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_addr      <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_instr <= '0;
      r_rsp_fault <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (req_valid_i) begin
            r_addr <= req_addr_i;
            if (LATENCY == 1) begin
              r_state     <= RESP;
              r_rsp_valid <= 1'b1;
              r_rsp_instr <= w_rsp_data;
              r_rsp_fault <= w_fault;
            end else begin
              r_state <= WAIT;
              r_cnt   <= CNT_LOAD;
            end
          end
        end
        WAIT: begin
          if (r_cnt == 4'd0) begin
            r_state     <= RESP;
            r_rsp_valid <= 1'b1;
            r_rsp_instr <= w_rsp_data;
            r_rsp_fault <= w_fault;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        RESP: begin
          if (r_rsp_valid && rsp_ready_i) begin
            r_state     <= IDLE;
            r_rsp_valid <= 1'b0;
            r_rsp_instr <= '0;
            r_rsp_fault <= 1'b0;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_rsp_valid <= 1'b0;
          r_rsp_instr <= '0;
          r_rsp_fault <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready_o = (r_state == IDLE);
  assign rsp_valid_o = r_rsp_valid;
  assign rsp_instr_o = r_rsp_instr;
  assign rsp_fault_o = r_rsp_fault;

endmodule : imem_responder

`default_nettype wire

// File: tb/tb_imem_responder.sv
// ============================================================================
// Module      : tb_imem_responder
// Description : Self-checking bench driving three responders (LATENCY 1/2/5).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_imem_responder;

  localparam int          DEPTH = 1024;
  localparam int          NDUT  = 3;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic        clk;
  logic        rstn;
  logic        wr_en;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;

  logic        req_valid [NDUT];
  logic [31:0] req_addr  [NDUT];
  logic        rsp_ready [NDUT];
  logic        req_ready [NDUT];
  logic        rsp_valid [NDUT];
  logic [31:0] rsp_instr [NDUT];
  logic        rsp_fault [NDUT];

  logic [31:0] mem_m [DEPTH];
  int          checks = 0;
  int          errors = 0;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    localparam int LAT = (g == 0) ? 1 : ((g == 1) ? 2 : 5);
    imem_responder #(
      .LATENCY     (LAT),
      .DEPTH_WORDS (DEPTH)
    ) dut (
      .clk_i       (clk),
      .rstn_i      (rstn),
      .req_valid_i (req_valid[g]),
      .req_ready_o (req_ready[g]),
      .req_addr_i  (req_addr[g]),
      .rsp_valid_o (rsp_valid[g]),
      .rsp_ready_i (rsp_ready[g]),
      .rsp_instr_o (rsp_instr[g]),
      .rsp_fault_o (rsp_fault[g]),
      .wr_en_i     (wr_en),
      .wr_addr_i   (wr_addr),
      .wr_data_i   (wr_data)
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int lat_of(input int d);
    return (d == 0) ? 1 : ((d == 1) ? 2 : 5);
  endfunction

  // Reference: what a fetch of byte address a must return given memory now.
  function automatic void model_rsp(input logic [31:0] a, output logic [31:0] ei, output logic ef);
`ifdef IMEM_FAULT_EN
    if ((a % 4) != 0 || longint'(a) >= longint'(4 * DEPTH)) begin
      ei = NOP;
      ef = 1'b1;
      return;
    end
`endif
    ei = mem_m[(a / 4) % DEPTH];
    ef = 1'b0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  task automatic chk_idle(input string tag, input int d);
    chk({tag, "_ready"}, 32'(req_ready[d]), 32'd1);
    chk({tag, "_valid"}, 32'(rsp_valid[d]), 32'd0);
    chk({tag, "_instr"}, rsp_instr[d], 32'd0);
    chk({tag, "_fault"}, 32'(rsp_fault[d]), 32'd0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_word(input int idx, input logic [31:0] data);
    wr_en   = 1'b1;
    wr_addr = 32'(idx * 4) | 32'($urandom_range(0, 3));
    wr_data = data;
    step();
    mem_m[idx] = data;
    wr_en = 1'b0;
  endtask

  // One complete fetch on DUT d. wr_off >= 0 writes wr_val to the in-flight
  // word on that edge (0 = accept edge); stall = cycles with rsp_ready low.
  task automatic fetch(input int d, input logic [31:0] addr, input int stall,
                       input int wr_off, input logic [31:0] wr_val);
    int          lat;
    logic [31:0] ei;
    logic        ef;
    lat = lat_of(d);
    ei  = '0;
    ef  = 1'b0;
    chk("pre_ready", 32'(req_ready[d]), 32'd1);
    req_valid[d] = 1'b1;
    req_addr[d]  = addr;
    for (int e = 0; e < lat; e++) begin
      if (e == wr_off) begin
        wr_en   = 1'b1;
        wr_addr = addr & ~32'd3;
        wr_data = wr_val;
      end
      if (e == lat - 1) model_rsp(addr, ei, ef);
      step();
      if (e == wr_off) begin
        mem_m[(addr / 4) % DEPTH] = wr_val;
        wr_en = 1'b0;
      end
      req_valid[d] = 1'b0;
      if (e < lat - 1) begin
        chk("wait_valid", 32'(rsp_valid[d]), 32'd0);
        chk("wait_ready", 32'(req_ready[d]), 32'd0);
      end
    end
    chk("rsp_valid", 32'(rsp_valid[d]), 32'd1);
    chk("rsp_instr", rsp_instr[d], ei);
    chk("rsp_fault", 32'(rsp_fault[d]), 32'(ef));
    chk("rsp_ready_lo", 32'(req_ready[d]), 32'd0);
    for (int s = 0; s < stall; s++) begin
      rsp_ready[d] = 1'b0;
      req_valid[d] = 1'b1;
      req_addr[d]  = ~addr;
      step();
      chk("stall_valid", 32'(rsp_valid[d]), 32'd1);
      chk("stall_instr", rsp_instr[d], ei);
      chk("stall_fault", 32'(rsp_fault[d]), 32'(ef));
      chk("stall_ready", 32'(req_ready[d]), 32'd0);
    end
    req_valid[d] = 1'b0;
    rsp_ready[d] = 1'b1;
    step();
    rsp_ready[d] = 1'b0;
    chk_idle("post_hs", d);
  endtask

  initial begin
    logic [31:0] a;
    int          d;
    int          wo;
    rstn    = 1'b0;
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    for (int i = 0; i < NDUT; i++) begin
      req_valid[i] = 1'b0;
      req_addr[i]  = '0;
      rsp_ready[i] = 1'b0;
    end
    #2;
    for (int i = 0; i < NDUT; i++) chk_idle("reset", i);
    #10 rstn = 1'b1;

    for (int i = 0; i < DEPTH; i++) wr_word(i, $urandom);

    // Basic fetch, latency 2
    wr_word(5, 32'hDEAD_BEEF);
    fetch(1, 32'h14, 0, -1, '0);

    // Back-to-back at latency 1
    fetch(0, 32'h0, 0, -1, '0);
    fetch(0, 32'h4, 0, -1, '0);

    // Long stall with a competing request held high
    fetch(1, 32'h20, 5, -1, '0);
    fetch(2, 32'h24, 5, -1, '0);

    // Misaligned and out-of-range addresses
    fetch(1, 32'h2, 0, -1, '0);
    fetch(1, 32'(4 * DEPTH), 0, -1, '0);
    fetch(0, 32'(4 * DEPTH + 8), 1, -1, '0);

    // Write before vs. on the RESP-entry edge
    fetch(1, 32'h1C, 0, 0, 32'h1111_1111);
    fetch(1, 32'h1C, 0, 1, 32'h2222_2222);
    fetch(1, 32'h1C, 0, -1, '0);
    fetch(2, 32'h30, 0, 3, 32'h3333_3333);
    fetch(2, 32'h30, 0, 4, 32'h4444_4444);
    fetch(0, 32'h30, 0, 0, 32'h5555_5555);

    // Reset in the middle of WAIT aborts the request
    wr_word(9, 32'hCAFE_F00D);
    req_valid[2] = 1'b1;
    req_addr[2]  = 32'h24;
    step();
    req_valid[2] = 1'b0;
    step();
    chk("mid_wait_ready", 32'(req_ready[2]), 32'd0);
    #2 rstn = 1'b0;
    #1;
    for (int i = 0; i < NDUT; i++) chk_idle("async_rst", i);
    step();
    #3 rstn = 1'b1;
    for (int c = 0; c < 8; c++) begin
      step();
      chk("no_rsp_after_rst", 32'(rsp_valid[2]), 32'd0);
    end
    fetch(2, 32'h24, 0, -1, '0);
    fetch(1, 32'h14, 0, -1, '0);

    // Randomized traffic
    for (int n = 0; n < 60; n++) begin
      d = $urandom_range(0, NDUT - 1);
      if ($urandom_range(0, 3) == 0) a = $urandom;
      else a = 32'($urandom_range(0, DEPTH - 1) * 4);
      wo = ($urandom_range(0, 2) == 0) ? $urandom_range(0, lat_of(d) - 1) : -1;
      fetch(d, a, $urandom_range(0, 3), wo, $urandom);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_imem_responder

`default_nettype wire
